led_scan_decoder: RTL and testbench

//  Receive-side counterpart of the four-digit LED driver: samples the multiplexed anode/segment bus
//  (an3..an0, a..g, all active-low), waits for each digit phase to settle, decodes the segment

---
 rtl/led_scan_decoder_pkg.sv | 35 +++
 rtl/led_scan_decoder_seg7_to_hex.sv | 34 +++
 rtl/led_scan_decoder.sv | 182 ++++++++++++++++++
 tb/tb_led_scan_decoder.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/led_scan_decoder_pkg.sv
// Shared seven-segment and anode encodings for the LED driver and its scan decoder.
// All codes are active-low, segment order {a,b,c,d,e,f,g}.
package led_scan_decoder_pkg;

   localparam logic [6:0] SEG_0     = 7'h01;
   localparam logic [6:0] SEG_1     = 7'h4F;
   localparam logic [6:0] SEG_2     = 7'h12;
   localparam logic [6:0] SEG_3     = 7'h06;
   localparam logic [6:0] SEG_4     = 7'h4C;
   localparam logic [6:0] SEG_5     = 7'h24;
   localparam logic [6:0] SEG_6     = 7'h20;
   localparam logic [6:0] SEG_7     = 7'h0F;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h04;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_B     = 7'h60;
   localparam logic [6:0] SEG_C     = 7'h31;
   localparam logic [6:0] SEG_D     = 7'h42;
   localparam logic [6:0] SEG_E     = 7'h30;
   localparam logic [6:0] SEG_F     = 7'h38;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [3:0] AN_NONE = 4'b1111;
   localparam logic [3:0] AN_DIG0 = 4'b1110;
   localparam logic [3:0] AN_DIG1 = 4'b1101;
   localparam logic [3:0] AN_DIG2 = 4'b1011;
   localparam logic [3:0] AN_DIG3 = 4'b0111;

   typedef enum logic [1:0] {
      ST_WAIT_CHANGE = 2'd0,
      ST_SETTLING    = 2'd1,
      ST_EVALUATE    = 2'd2
   } scan_state_e;

endpackage

// File: rtl/led_scan_decoder_seg7_to_hex.sv
// Combinational seven-segment to hex decoder; valid is low for any code outside the table.
module led_scan_decoder_seg7_to_hex
   import led_scan_decoder_pkg::*;
(
   input  logic [6:0] seg,
   output logic       valid,
   output logic [3:0] hex
);

   always_comb begin
      valid = 1'b1;
      hex   = 4'h0;
      case (seg)
         SEG_0:   hex = 4'h0;
         SEG_1:   hex = 4'h1;
         SEG_2:   hex = 4'h2;
         SEG_3:   hex = 4'h3;
         SEG_4:   hex = 4'h4;
         SEG_5:   hex = 4'h5;
         SEG_6:   hex = 4'h6;
         SEG_7:   hex = 4'h7;
         SEG_8:   hex = 4'h8;
         SEG_9:   hex = 4'h9;
         SEG_A:   hex = 4'hA;
         SEG_B:   hex = 4'hB;
         SEG_C:   hex = 4'hC;
         SEG_D:   hex = 4'hD;
         SEG_E:   hex = 4'hE;
         SEG_F:   hex = 4'hF;
         default: valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/led_scan_decoder.sv
// Samples a multiplexed four-digit LED bus, waits for each phase to settle, decodes it
// and publishes all four characters together once every slot has been captured.
module led_scan_decoder
   import led_scan_decoder_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES  = 8,
   parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       an3,
   input  logic       an2,
   input  logic       an1,
   input  logic       an0,
   input  logic       a,
   input  logic       b,
   input  logic       c,
   input  logic       d,
   input  logic       e,
   input  logic       f,
   input  logic       g,
   output logic [3:0] digit3,
   output logic [3:0] digit2,
   output logic [3:0] digit1,
   output logic [3:0] digit0,
   output logic       frame_valid,
   output logic       digits_valid,
   output logic       seg_err,
   output logic       an_err
);

   localparam logic [7:0]  SETTLE_MAX  = 8'(SETTLE_CYCLES);
   localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [23:0] TMO_RELOAD  = 24'(TIMEOUT_CYCLES - 1);

   logic [10:0] sync1_q, sync2_q, vec_prev_q;
   logic        first_q;
   logic [7:0]  cnt_q, cnt_d;
   scan_state_e state_q, state_d;
   logic [15:0] shadow_q, shadow_d, digits_q, digits_d;
   logic [3:0]  mask_q, mask_d;
   logic [23:0] tmo_q, tmo_d;
   logic        frame_valid_q, frame_valid_d, digits_valid_q, digits_valid_d;
   logic        seg_err_q, seg_err_d, an_err_q, an_err_d;

   logic        changed_s, one_low_s, multi_low_s, dec_valid_s;
   logic [1:0]  slot_s;
   logic [3:0]  dec_hex_s;

   // vec_prev_q holds the vector the settle decision was made on, so EVALUATE decodes it
   led_scan_decoder_seg7_to_hex u_seg7_to_hex (
      .seg   (vec_prev_q[6:0]),
      .valid (dec_valid_s),
      .hex   (dec_hex_s)
   );

   always_comb begin
      changed_s   = first_q || (sync2_q != vec_prev_q);
      one_low_s   = 1'b1;
      multi_low_s = 1'b0;
      slot_s      = 2'd0;
      case (vec_prev_q[10:7])
         AN_DIG0: slot_s = 2'd0;
         AN_DIG1: slot_s = 2'd1;
         AN_DIG2: slot_s = 2'd2;
         AN_DIG3: slot_s = 2'd3;
         AN_NONE: one_low_s = 1'b0;
         default: begin
            one_low_s   = 1'b0;
            multi_low_s = 1'b1;
         end
      endcase

      if (changed_s) cnt_d = 8'd0;
      else if (cnt_q == SETTLE_MAX) cnt_d = cnt_q;
      else cnt_d = cnt_q + 8'd1;

      state_d = state_q;
      case (state_q)
         ST_WAIT_CHANGE: begin
            if (changed_s) state_d = ST_SETTLING;
            else state_d = ST_WAIT_CHANGE;
         end
         ST_SETTLING: begin
            if (!changed_s && cnt_q == SETTLE_LAST) state_d = ST_EVALUATE;
            else state_d = ST_SETTLING;
         end
         ST_EVALUATE: begin
            if (changed_s) state_d = ST_SETTLING;
            else state_d = ST_WAIT_CHANGE;
         end
         default: state_d = ST_WAIT_CHANGE;
      endcase

      mask_d         = mask_q;
      shadow_d       = shadow_q;
      digits_d       = digits_q;
      digits_valid_d = digits_valid_q;
      frame_valid_d  = 1'b0;
      seg_err_d      = 1'b0;
      an_err_d       = 1'b0;

      if (tmo_q != 24'd0) begin
         tmo_d = tmo_q - 24'd1;
      end else begin
         tmo_d          = tmo_q;
         mask_d         = 4'b0000;
         digits_valid_d = 1'b0;
      end

      // Publishing uses the pre-update shadow; a capture this cycle lands in the cleared mask
      if (mask_q == 4'b1111) begin
         digits_d       = shadow_q;
         frame_valid_d  = 1'b1;
         digits_valid_d = 1'b1;
         mask_d         = 4'b0000;
      end else begin
         digits_d = digits_q;
      end

      if (state_q == ST_EVALUATE) begin
         if (multi_low_s) begin
            an_err_d = 1'b1;
         end else if (one_low_s && dec_valid_s) begin
            shadow_d[{slot_s, 2'b00} +: 4] = dec_hex_s;
            mask_d[slot_s]                 = 1'b1;
            tmo_d                          = TMO_RELOAD;
         end else if (one_low_s) begin
            seg_err_d      = 1'b1;
            mask_d[slot_s] = 1'b0;
         end else begin
            an_err_d = 1'b0;
         end
      end else begin
         an_err_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q        <= {AN_NONE, SEG_BLANK};
         sync2_q        <= {AN_NONE, SEG_BLANK};
         vec_prev_q     <= {AN_NONE, SEG_BLANK};
         first_q        <= 1'b1;
         cnt_q          <= 8'd0;
         state_q        <= ST_WAIT_CHANGE;
         shadow_q       <= 16'h0000;
         mask_q         <= 4'b0000;
         tmo_q          <= 24'd0;
         digits_q       <= 16'h0000;
         frame_valid_q  <= 1'b0;
         digits_valid_q <= 1'b0;
         seg_err_q      <= 1'b0;
         an_err_q       <= 1'b0;
      end else begin
         sync1_q        <= {an3, an2, an1, an0, a, b, c, d, e, f, g};
         sync2_q        <= sync1_q;
         vec_prev_q     <= sync2_q;
         first_q        <= 1'b0;
         cnt_q          <= cnt_d;
         state_q        <= state_d;
         shadow_q       <= shadow_d;
         mask_q         <= mask_d;
         tmo_q          <= tmo_d;
         digits_q       <= digits_d;
         frame_valid_q  <= frame_valid_d;
         digits_valid_q <= digits_valid_d;
         seg_err_q      <= seg_err_d;
         an_err_q       <= an_err_d;
      end
   end

   assign digit3       = digits_q[15:12];
   assign digit2       = digits_q[11:8];
   assign digit1       = digits_q[7:4];
   assign digit0       = digits_q[3:0];
   assign frame_valid  = frame_valid_q;
   assign digits_valid = digits_valid_q;
   assign seg_err      = seg_err_q;
   assign an_err       = an_err_q;

endmodule

// File: tb/tb_led_scan_decoder.sv
// Scoreboard bench for led_scan_decoder: expected frames are queued as scans are driven
// and compared when frame_valid fires.
module tb_led_scan_decoder;

   logic       clk = 1'b0;
   logic       reset;
   logic       an3, an2, an1, an0, a, b, c, d, e, f, g;
   logic [3:0] digit3, digit2, digit1, digit0;
   logic       frame_valid, digits_valid, seg_err, an_err;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [15:0] sb_q[$];
   logic [15:0] exp_frame;
   int          frames_seen = 0, an_err_cnt = 0, seg_err_cnt = 0;
   int          cyc = 0, last_frame_cyc = 0, dv_fall_cyc = 0;
   logic        prev_dv = 1'b0;

   always #5 clk = ~clk;

   led_scan_decoder #(
      .SETTLE_CYCLES  (8),
      .TIMEOUT_CYCLES (64)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .an3          (an3),
      .an2          (an2),
      .an1          (an1),
      .an0          (an0),
      .a            (a),
      .b            (b),
      .c            (c),
      .d            (d),
      .e            (e),
      .f            (f),
      .g            (g),
      .digit3       (digit3),
      .digit2       (digit2),
      .digit1       (digit1),
      .digit0       (digit0),
      .frame_valid  (frame_valid),
      .digits_valid (digits_valid),
      .seg_err      (seg_err),
      .an_err       (an_err)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic show(input logic [3:0] an, input logic [6:0] seg, input int n);
      {an3, an2, an1, an0} = an;
      {a, b, c, d, e, f, g} = seg;
      repeat (n) @(posedge clk);
   endtask

   // Frame scoreboard and pulse monitor, sampled away from the active edge
   always @(negedge clk) begin
      cyc++;
      if (!reset) begin
         if (frame_valid) begin
            frames_seen++;
            last_frame_cyc = cyc;
            check("frame_pending", int'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
               exp_frame = sb_q.pop_front();
               check("frame_digits", int'({digit3, digit2, digit1, digit0}), int'(exp_frame));
            end
            check("dv_with_frame", int'(digits_valid), 1);
         end
         if (an_err) an_err_cnt++;
         if (seg_err) seg_err_cnt++;
         if (an_err || seg_err) check("err_exclusive", int'(an_err & seg_err), 0);
         if (prev_dv && !digits_valid) dv_fall_cyc = cyc;
      end
      prev_dv = digits_valid;
   end

   initial begin
      reset = 1'b1;
      show(4'b1111, 7'h7F, 3);
      @(negedge clk);
      check("rst_digits", int'({digit3, digit2, digit1, digit0}), 0);
      check("rst_frame_valid", int'(frame_valid), 0);
      check("rst_digits_valid", int'(digits_valid), 0);
      check("rst_seg_err", int'(seg_err), 0);
      check("rst_an_err", int'(an_err), 0);
      reset = 1'b0;

      // Basic scan 1,2,3,4 on an0..an3
      show(4'b1110, 7'h4F, 20);
      show(4'b1101, 7'h12, 20);
      show(4'b1011, 7'h06, 20);
      sb_q.push_back(16'h4321);
      show(4'b0111, 7'h4C, 20);
      @(negedge clk);
      check("scan1_dv", int'(digits_valid), 1);
      check("scan1_digits", int'({digit3, digit2, digit1, digit0}), 16'h4321);

      // Unsettled glitching under an2, then a steady A
      for (int i = 0; i < 3; i++) begin
         show(4'b1011, 7'h06, 5);
         show(4'b1011, 7'h12, 5);
      end
      show(4'b1011, 7'h08, 12);
      check("glitch_no_frame", frames_seen, 1);
      show(4'b0111, 7'h30, 20);
      show(4'b1101, 7'h24, 20);
      sb_q.push_back(16'hEA56);
      show(4'b1110, 7'h20, 20);
      check("glitch_errs", an_err_cnt + seg_err_cnt, 0);

      // Two anodes low in the middle of a scan
      show(4'b1110, 7'h04, 20);
      show(4'b1101, 7'h0F, 20);
      show(4'b1100, 7'h4F, 20);
      check("an_err_once", an_err_cnt, 1);
      show(4'b1011, 7'h06, 20);
      sb_q.push_back(16'hC379);
      show(4'b0111, 7'h31, 20);

      // Undecodable pattern must leave slot3 empty
      show(4'b0111, 7'h7E, 20);
      check("seg_err_once", seg_err_cnt, 1);
      show(4'b1110, 7'h60, 20);
      show(4'b1101, 7'h42, 20);
      show(4'b1011, 7'h01, 20);
      check("seg_err_no_frame", frames_seen, 3);
      sb_q.push_back(16'hF0DB);
      show(4'b0111, 7'h38, 20);
      check("seg_err_an_cnt", an_err_cnt, 1);

      // Blank display until the timeout expires
      show(4'b1111, 7'h7F, 70);
      @(negedge clk);
      check("tmo_dv_low", int'(digits_valid), 0);
      check("tmo_latency", dv_fall_cyc - last_frame_cyc, 63);
      check("tmo_digits_hold", int'({digit3, digit2, digit1, digit0}), 16'hF0DB);

      // Reset after three captures, then a fresh scan in reverse order
      show(4'b1110, 7'h4F, 20);
      show(4'b1101, 7'h12, 20);
      show(4'b1011, 7'h06, 20);
      reset = 1'b1;
      show(4'b1111, 7'h7F, 3);
      @(negedge clk);
      check("rst2_digits", int'({digit3, digit2, digit1, digit0}), 0);
      check("rst2_dv", int'(digits_valid), 0);
      reset = 1'b0;
      show(4'b0111, 7'h00, 20);
      show(4'b1011, 7'h00, 20);
      show(4'b1101, 7'h00, 20);
      check("rst2_no_early_frame", frames_seen, 4);
      sb_q.push_back(16'h8888);
      show(4'b1110, 7'h00, 20);
      show(4'b1111, 7'h7F, 10);
      @(negedge clk);
      check("rst2_dv_high", int'(digits_valid), 1);
      check("rst2_digits", int'({digit3, digit2, digit1, digit0}), 16'h8888);

      check("sb_empty", sb_q.size(), 0);
      check("frames_total", frames_seen, 5);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
